// File: rtl/uart_cmd_sequencer.sv
// Replays newline-terminated command strings from a synchronous ROM through a UART_TX byte
// handshake, optionally waiting for "OK\r\n" on the RX stream with timeout and bounded retries.
module uart_cmd_sequencer #(
  parameter int unsigned        N_CMDS       = 5,
  parameter int unsigned        MAX_LEN      = 64,
  parameter int unsigned        GAP_CLKS     = 32000,
  parameter int unsigned        TIMEOUT_CLKS = 1200000,
  parameter int unsigned        MAX_RETRY    = 3,
  parameter logic [N_CMDS-1:0]  WAIT_OK_MASK = 5'b01110,
  parameter bit                 REPEAT_LAST  = 1'b1,
  localparam int unsigned       CMD_W        = (N_CMDS > 1) ? $clog2(N_CMDS) : 1,
  localparam int unsigned       CHAR_W       = $clog2(MAX_LEN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic [CMD_W+CHAR_W-1:0] rom_addr,
  input  logic [7:0]              rom_data,
  output logic                    tx_dv,
  output logic [7:0]              tx_byte,
  input  logic                    tx_active,
  input  logic                    tx_done,
  input  logic                    rx_dv,
  input  logic [7:0]              rx_byte,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [CMD_W-1:0]        cur_cmd
);

  localparam int unsigned GapW   = $clog2(GAP_CLKS + 1);
  localparam int unsigned ToW    = $clog2(TIMEOUT_CLKS + 1);
  localparam int unsigned RetryW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [GapW-1:0]   GapLast  = GapW'(GAP_CLKS - 1);
  localparam logic [ToW-1:0]    ToLast   = ToW'(TIMEOUT_CLKS - 1);
  localparam logic [RetryW-1:0] RetryMax = RetryW'(MAX_RETRY);
  localparam logic [CMD_W-1:0]  CmdLast  = CMD_W'(N_CMDS - 1);
  localparam logic [CHAR_W-1:0] CharLast = CHAR_W'(MAX_LEN - 1);

  localparam logic [3:0] StIdle    = 4'd0;
  localparam logic [3:0] StGap     = 4'd1;
  localparam logic [3:0] StFetch   = 4'd2;
  localparam logic [3:0] StRomWait = 4'd3;
  localparam logic [3:0] StSend    = 4'd4;
  localparam logic [3:0] StWaitTx  = 4'd5;
  localparam logic [3:0] StWaitOk  = 4'd6;
  localparam logic [3:0] StNext    = 4'd7;
  localparam logic [3:0] StDone    = 4'd8;
  localparam logic [3:0] StError   = 4'd9;

  logic [3:0]        state_q, state_d;
  logic [CMD_W-1:0]  cmd_q, cmd_d;
  logic [CHAR_W-1:0] char_q, char_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [ToW-1:0]    to_q, to_d;
  logic [RetryW-1:0] retry_q, retry_d;
  logic [2:0]        match_q, match_d;
  logic [7:0]        tx_byte_q, tx_byte_d;
  logic              tx_dv_q, tx_dv_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              finish_cmd;
  logic [7:0]        ok_char;

  always_comb begin
    unique case (match_q)
      3'd0:    ok_char = "O";
      3'd1:    ok_char = "K";
      3'd2:    ok_char = 8'h0D;
      default: ok_char = 8'h0A;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cmd_d      = cmd_q;
    char_d     = char_q;
    gap_d      = gap_q;
    to_d       = to_q;
    retry_d    = retry_q;
    match_d    = match_q;
    tx_byte_d  = tx_byte_q;
    error_d    = error_q;
    tx_dv_d    = 1'b0;
    done_d     = 1'b0;
    finish_cmd = 1'b0;

    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          cmd_d   = '0;
          char_d  = '0;
          gap_d   = '0;
          retry_d = '0;
          error_d = 1'b0;
          state_d = StGap;
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          char_d  = '0;
          state_d = StFetch;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      StFetch: state_d = StRomWait;
      StRomWait: begin
        // A NUL ends the command; at char 0 it marks an empty slot that is skipped outright.
        if (rom_data == 8'h00) begin
          if (char_q == '0) state_d = StNext;
          else              finish_cmd = 1'b1;
        end else begin
          tx_byte_d = rom_data;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (!tx_active) begin
          tx_dv_d = 1'b1;
          state_d = StWaitTx;
        end
      end
      StWaitTx: begin
        if (tx_done) begin
          if (tx_byte_q == 8'h0A || char_q == CharLast) begin
            finish_cmd = 1'b1;
          end else begin
            char_d  = char_q + 1'b1;
            state_d = StFetch;
          end
        end
      end
      StWaitOk: begin
        // A completing match beats a timeout landing in the same cycle.
        if (rx_dv && rx_byte == ok_char && match_q == 3'd3) begin
          state_d = StNext;
        end else begin
          if (rx_dv) begin
            if (rx_byte == ok_char) match_d = match_q + 1'b1;
            else                    match_d = (rx_byte == "O") ? 3'd1 : 3'd0;
          end
          if (to_q == ToLast) begin
            if (retry_q < RetryMax) begin
              retry_d = retry_q + 1'b1;
              gap_d   = '0;
              char_d  = '0;
              state_d = StGap;
            end else begin
              error_d = 1'b1;
              state_d = StError;
            end
          end else begin
            to_d = to_q + 1'b1;
          end
        end
      end
      StNext: begin
        retry_d = '0;
        gap_d   = '0;
        char_d  = '0;
        if (cmd_q < CmdLast) begin
          cmd_d   = cmd_q + 1'b1;
          state_d = StGap;
        end else if (REPEAT_LAST) begin
          state_d = StGap;
        end else begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase

    if (finish_cmd) begin
      if (WAIT_OK_MASK[cmd_q]) begin
        to_d    = '0;
        match_d = '0;
        state_d = StWaitOk;
      end else begin
        state_d = StNext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      cmd_q     <= '0;
      char_q    <= '0;
      gap_q     <= '0;
      to_q      <= '0;
      retry_q   <= '0;
      match_q   <= '0;
      tx_byte_q <= '0;
      tx_dv_q   <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      char_q    <= char_d;
      gap_q     <= gap_d;
      to_q      <= to_d;
      retry_q   <= retry_d;
      match_q   <= match_d;
      tx_byte_q <= tx_byte_d;
      tx_dv_q   <= tx_dv_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  assign rom_addr = {cmd_q, char_q};
  assign tx_dv    = tx_dv_q;
  assign tx_byte  = tx_byte_q;
  assign done     = done_q;
  assign error    = error_q;
  assign cur_cmd  = cmd_q;
  assign busy     = (state_q != StIdle) && (state_q != StDone) && (state_q != StError);

endmodule
